// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential divider.
// The requester drives the master side; the divider implements the slave side.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock on operand magnitudes,
// followed by a single sign-correction cycle that loads the held result registers.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("seq_divider: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   r_prem;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_dvsr_mag;
  logic [WIDTH-1:0] r_dvd_orig;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_next;
  logic             w_carry;
  logic             w_unused_msb;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  // The most-negative value maps to 2^(WIDTH-1), which is still representable unsigned.
  function automatic logic [WIDTH-1:0] f_mag(input logic signed [WIDTH-1:0] v,
                                             input logic is_signed);
    return (is_signed && v < 0) ? f_neg(v) : v;
  endfunction

  // Trial subtract as add-complement; carry-out set means no borrow.
  assign w_shift = {r_prem[WIDTH-1:0], r_work[WIDTH-1]};
  assign {w_carry, w_diff} = {1'b0, w_shift} + {1'b0, 1'b1, ~r_dvsr_mag} + (WIDTH+2)'(1);
  assign w_next = w_carry ? w_diff : w_shift;
  // After each restore the partial remainder is below the divisor, so its top bit stays clear.
  assign w_unused_msb = r_prem[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= FIX;
        end
        FIX: begin
          r_quot  <= r_zero  ? '1 : (r_neg_q ? f_neg(r_work) : r_work);
          r_rem   <= r_zero  ? r_dvd_orig
                             : (r_neg_r ? f_neg(r_prem[WIDTH-1:0]) : r_prem[WIDTH-1:0]);
          r_dbz   <= r_zero;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; the state machine decides when they matter.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.start) begin
      r_prem     <= '0;
      r_work     <= f_mag(bus.dividend, bus.signed_op);
      r_dvsr_mag <= f_mag(bus.divisor, bus.signed_op);
      r_dvd_orig <= bus.dividend;
      r_zero     <= (bus.divisor == '0);
      r_neg_q    <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg_r    <= bus.signed_op & bus.dividend[WIDTH-1];
    end else if (r_state == RUN) begin
      r_prem <= w_next;
      r_work <= {r_work[WIDTH-2:0], w_carry};
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: per-scenario tasks, expected results queued at launch
// and compared when done pulses.
module tb_seq_divider;

  localparam int W = 16;

  logic clk;
  logic rst_n;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sb_i;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else if (!s) begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end else begin
      sa   = int'($signed(a));
      sb_i = int'($signed(b));
      e.q  = W'(sa / sb_i);
      e.r  = W'(sa % sb_i);
      e.z  = 1'b0;
    end
    return e;
  endfunction

  // Drives a one-cycle start, queues the expected result, then scrambles the operands.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.dividend  = a;
    bus.divisor   = b;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    bus.start     = 1'b0;
    bus.signed_op = 1'($urandom);
    bus.dividend  = W'($urandom);
    bus.divisor   = W'($urandom);
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.done !== 1'b1 && n < limit);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", bus.done); end
    n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL rst_quotient: got %h, expected 0000", bus.quotient); end
    n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL rst_remainder: got %h, expected 0000", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dbz: got %b, expected 0", bus.div_by_zero); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b, expected 0", bus.busy); end
  endtask

  task automatic test_unsigned();
    logic [W-1:0] ta[5] = '{16'd100, 16'hFFFF, 16'd5, 16'hFFFF, 16'h8000};
    logic [W-1:0] tb[5] = '{16'd7,   16'h0001, 16'd9, 16'h0100, 16'h0003};
    int    n;
    exp_t  e;
    string nm;
    for (int i = 0; i < 5; i++) begin
      nm = $sformatf("unsigned%0d", i);
      launch(ta[i], tb[i], 1'b0);
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b, expected 1", nm, bus.busy); end
      wait_done(40, n);
      n_checks++; if (n !== 17) begin n_fail++; $display("FAIL %s latency: got %0d cycles, expected 17", nm, n); end
      if (bus.done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL %s quotient: got %h, expected %h", nm, bus.quotient, e.q); end
        n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL %s remainder: got %h, expected %h", nm, bus.remainder, e.r); end
        n_checks++; if (bus.div_by_zero !== e.z) begin n_fail++; $display("FAIL %s dbz: got %b, expected %b", nm, bus.div_by_zero, e.z); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_at_done: got %b, expected 0", nm, bus.busy); end
      end else begin
        n_checks++; n_fail++; $display("FAIL %s result: done not seen (got none, expected pulse)", nm);
      end
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta[6] = '{16'hFFF9, 16'h0007, 16'h8000, 16'hFFF9, 16'h8000, 16'h7FFF};
    logic [W-1:0] tb[6] = '{16'h0002, 16'hFFFE, 16'hFFFF, 16'hFFFE, 16'h0001, 16'h8000};
    int    n;
    exp_t  e;
    string nm;
    for (int i = 0; i < 6; i++) begin
      nm = $sformatf("signed%0d", i);
      launch(ta[i], tb[i], 1'b1);
      wait_done(40, n);
      n_checks++; if (n !== 17) begin n_fail++; $display("FAIL %s latency: got %0d cycles, expected 17", nm, n); end
      if (bus.done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL %s quotient: got %h, expected %h", nm, bus.quotient, e.q); end
        n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL %s remainder: got %h, expected %h", nm, bus.remainder, e.r); end
        n_checks++; if (bus.div_by_zero !== e.z) begin n_fail++; $display("FAIL %s dbz: got %b, expected %b", nm, bus.div_by_zero, e.z); end
      end else begin
        n_checks++; n_fail++; $display("FAIL %s result: done not seen (got none, expected pulse)", nm);
      end
    end
  endtask

  task automatic test_div_zero_hold();
    int   n;
    exp_t e;
    exp_t held;
    launch(16'h04D2, 16'h0000, 1'b0);
    wait_done(40, n);
    n_checks++; if (n !== 17) begin n_fail++; $display("FAIL dbz latency: got %0d cycles, expected 17", n); end
    held = '{q: '1, r: 16'h04D2, z: 1'b1};
    if (bus.done === 1'b1 && sb.size() > 0) begin
      held = sb.pop_front();
      n_checks++; if (bus.quotient !== held.q) begin n_fail++; $display("FAIL dbz quotient: got %h, expected %h", bus.quotient, held.q); end
      n_checks++; if (bus.remainder !== held.r) begin n_fail++; $display("FAIL dbz remainder: got %h, expected %h", bus.remainder, held.r); end
      n_checks++; if (bus.div_by_zero !== held.z) begin n_fail++; $display("FAIL dbz flag: got %b, expected %b", bus.div_by_zero, held.z); end
    end else begin
      n_checks++; n_fail++; $display("FAIL dbz result: done not seen (got none, expected pulse)");
    end
    repeat (5) @(negedge clk);
    n_checks++; if (bus.quotient !== held.q || bus.remainder !== held.r || bus.div_by_zero !== held.z)
      begin n_fail++; $display("FAIL hold_idle: got %h/%h/%b, expected %h/%h/%b", bus.quotient, bus.remainder, bus.div_by_zero, held.q, held.r, held.z); end
    launch(16'd9, 16'd3, 1'b0);
    repeat (8) @(negedge clk);
    n_checks++; if (bus.quotient !== held.q || bus.remainder !== held.r || bus.div_by_zero !== held.z)
      begin n_fail++; $display("FAIL hold_run: got %h/%h/%b, expected %h/%h/%b", bus.quotient, bus.remainder, bus.div_by_zero, held.q, held.r, held.z); end
    wait_done(40, n);
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL after_dbz latency: got %0d cycles, expected 9", n); end
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL after_dbz quotient: got %h, expected %h", bus.quotient, e.q); end
      n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL after_dbz remainder: got %h, expected %h", bus.remainder, e.r); end
      n_checks++; if (bus.div_by_zero !== e.z) begin n_fail++; $display("FAIL after_dbz flag: got %b, expected %b", bus.div_by_zero, e.z); end
    end else begin
      n_checks++; n_fail++; $display("FAIL after_dbz result: done not seen (got none, expected pulse)");
    end
    launch(16'hFFF9, 16'h0000, 1'b1);
    wait_done(40, n);
    n_checks++; if (n !== 17) begin n_fail++; $display("FAIL sdbz latency: got %0d cycles, expected 17", n); end
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL sdbz quotient: got %h, expected %h", bus.quotient, e.q); end
      n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL sdbz remainder: got %h, expected %h", bus.remainder, e.r); end
      n_checks++; if (bus.div_by_zero !== e.z) begin n_fail++; $display("FAIL sdbz flag: got %b, expected %b", bus.div_by_zero, e.z); end
    end else begin
      n_checks++; n_fail++; $display("FAIL sdbz result: done not seen (got none, expected pulse)");
    end
  endtask

  task automatic test_ignore_start();
    int   n;
    int   extra;
    exp_t e;
    launch(16'd1000, 16'd9, 1'b0);
    repeat (4) @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = 1'b1;
    bus.dividend  = 16'd7;
    bus.divisor   = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40, n);
    n_checks++; if (n !== 12) begin n_fail++; $display("FAIL ignore latency: got %0d cycles, expected 12", n); end
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL ignore quotient: got %h, expected %h", bus.quotient, e.q); end
      n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL ignore remainder: got %h, expected %h", bus.remainder, e.r); end
    end else begin
      n_checks++; n_fail++; $display("FAIL ignore result: done not seen (got none, expected pulse)");
    end
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore extra_activity: got %0d active cycles, expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int   n;
    exp_t e;
    launch(16'd50000, 16'd123, 1'b0);
    wait_done(40, n);
    n_checks++; if (n !== 17) begin n_fail++; $display("FAIL b2b_first latency: got %0d cycles, expected 17", n); end
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL b2b_first quotient: got %h, expected %h", bus.quotient, e.q); end
      n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL b2b_first remainder: got %h, expected %h", bus.remainder, e.r); end
    end else begin
      n_checks++; n_fail++; $display("FAIL b2b_first result: done not seen (got none, expected pulse)");
    end
    bus.start     = 1'b1;
    bus.signed_op = 1'b1;
    bus.dividend  = 16'hD8F1;
    bus.divisor   = 16'h0013;
    sb.push_back(model(16'hD8F1, 16'h0013, 1'b1));
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b busy: got %b, expected 1", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b done_width: got %b, expected 0", bus.done); end
    wait_done(40, n);
    n_checks++; if (n !== 17) begin n_fail++; $display("FAIL b2b_second latency: got %0d cycles, expected 17", n); end
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL b2b_second quotient: got %h, expected %h", bus.quotient, e.q); end
      n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL b2b_second remainder: got %h, expected %h", bus.remainder, e.r); end
      n_checks++; if (bus.div_by_zero !== e.z) begin n_fail++; $display("FAIL b2b_second dbz: got %b, expected %b", bus.div_by_zero, e.z); end
    end else begin
      n_checks++; n_fail++; $display("FAIL b2b_second result: done not seen (got none, expected pulse)");
    end
  endtask

  task automatic test_reset_mid();
    int   n;
    int   extra;
    exp_t e;
    launch(16'h1234, 16'h0005, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b, expected 0", bus.done); end
    n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL midrst_quotient: got %h, expected 0000", bus.quotient); end
    n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL midrst_remainder: got %h, expected 0000", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_dbz: got %b, expected 0", bus.div_by_zero); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.quotient !== '0) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles, expected 0", extra); end
    launch(16'd100, 16'd7, 1'b0);
    wait_done(40, n);
    n_checks++; if (n !== 17) begin n_fail++; $display("FAIL postrst latency: got %0d cycles, expected 17", n); end
    if (bus.done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL postrst quotient: got %h, expected %h", bus.quotient, e.q); end
      n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL postrst remainder: got %h, expected %h", bus.remainder, e.r); end
    end else begin
      n_checks++; n_fail++; $display("FAIL postrst result: done not seen (got none, expected pulse)");
    end
  endtask

  task automatic test_random();
    int           n;
    exp_t         e;
    string        nm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    for (int i = 0; i < 30; i++) begin
      nm = $sformatf("random%0d", i);
      a  = W'($urandom);
      s  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom);
        default: b = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h8000;
      endcase
      launch(a, b, s);
      wait_done(40, n);
      n_checks++; if (n !== 17) begin n_fail++; $display("FAIL %s latency: got %0d cycles, expected 17", nm, n); end
      if (bus.done === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL %s quotient (%h/%h s=%b): got %h, expected %h", nm, a, b, s, bus.quotient, e.q); end
        n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL %s remainder (%h/%h s=%b): got %h, expected %h", nm, a, b, s, bus.remainder, e.r); end
        n_checks++; if (bus.div_by_zero !== e.z) begin n_fail++; $display("FAIL %s dbz: got %b, expected %b", nm, bus.div_by_zero, e.z); end
      end else begin
        n_checks++; n_fail++; $display("FAIL %s result: done not seen (got none, expected pulse)", nm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero_hold();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
